// File: rtl/gsim_pkg.sv
// Shared constants and the feeder state type for the GSIM solver front end.
package gsim_pkg;

    localparam int VEC_LEN = 16;
    localparam int B_WIDTH = 16;
    localparam int X_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_BURST     = 2'd1,
        ST_WAIT_RES  = 2'd2,
        ST_WAIT_DONE = 2'd3
    } feeder_state_e;

    function automatic logic state_busy(input feeder_state_e s);
        return s != ST_IDLE;
    endfunction

endpackage

// File: rtl/gsim_fifo.sv
// Single-clock sample FIFO with occupancy count; head word is read straight from storage.
module gsim_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rptr];
    assign o_count = r_count;

endmodule

// File: rtl/gsim_feeder.sv
// Buffers host b samples and streams them to the GSIM solver in fixed-length bursts,
// then tracks the solver's result phase with a timeout.
module gsim_feeder #(
    parameter int DEPTH   = 32,
    parameter int VEC_LEN = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          s_valid,
    input  logic [gsim_pkg::B_WIDTH-1:0]  s_data,
    output logic                          s_ready,
    output logic                          in_en,
    output logic [gsim_pkg::B_WIDTH-1:0]  b_in,
    input  logic                          out_valid,
    output logic                          busy,
    output logic                          err
);

    import gsim_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int BW = $clog2(VEC_LEN);
    localparam int WW = $clog2(TIMEOUT);

    feeder_state_e       r_state;
    logic [BW-1:0]       r_beat;
    logic [WW-1:0]       r_wait;
    logic                r_err;

    logic [CW-1:0]       w_count;
    logic [B_WIDTH-1:0]  w_head;
    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;

    assign s_ready = !w_full;
    assign w_push  = s_valid && s_ready;
    assign w_pop   = (r_state == ST_BURST) && !w_empty;

    gsim_fifo #(
        .WIDTH (B_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (s_data),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_beat  <= '0;
            r_wait  <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_beat <= '0;
                    r_wait <= '0;
                    // Only a fully buffered vector may start a burst.
                    if (w_count >= CW'(VEC_LEN)) begin
                        r_state <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (r_beat == BW'(VEC_LEN - 1)) begin
                        r_beat  <= '0;
                        r_wait  <= '0;
                        r_state <= ST_WAIT_RES;
                    end else begin
                        r_beat <= r_beat + BW'(1);
                    end
                end
                ST_WAIT_RES: begin
                    if (out_valid) begin
                        r_state <= ST_WAIT_DONE;
                    end else if (r_wait == WW'(TIMEOUT - 1)) begin
                        r_err   <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_wait <= r_wait + WW'(1);
                    end
                end
                ST_WAIT_DONE: begin
                    if (!out_valid) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Outputs decode registered state and FIFO storage only.
    assign in_en = (r_state == ST_BURST);
    assign b_in  = in_en ? w_head : '0;
    assign busy  = state_busy(r_state);
    assign err   = r_err;

endmodule

// File: tb/tb_gsim_feeder.sv
// Self-checking bench for gsim_feeder: scoreboard of pushed samples against b_in,
// plus directed runs for threshold, back-to-back, full FIFO, timeout and reset.
module tb_gsim_feeder;

    import gsim_pkg::*;

    localparam int DEPTH = 32;
    localparam int TOUT  = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        s_valid = 1'b0;
    logic [15:0] s_data = '0;
    logic        s_ready;
    logic        in_en;
    logic [15:0] b_in;
    logic        out_valid = 1'b0;
    logic        busy;
    logic        err;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] sbq[$];
    int          m_cnt = 0;
    bit          mon_en = 1'b0;
    bit          stop_push = 1'b0;
    logic [15:0] seq = 16'h0100;

    typedef struct {
        logic [15:0] din;
        int          exp_cnt;
        logic        exp_ready;
    } vec_t;
    vec_t tbl[16];

    gsim_feeder #(
        .DEPTH   (DEPTH),
        .VEC_LEN (VEC_LEN),
        .TIMEOUT (TOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .in_en     (in_en),
        .b_in      (b_in),
        .out_valid (out_valid),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard consumer: every in_en cycle must present the oldest accepted sample.
    always @(negedge clk) begin
        if (mon_en) begin
            if (in_en === 1'b1) begin
                chk("busy_in_burst", busy, 1);
                if (sbq.size() == 0) chk("sb_underflow", sbq.size(), 1);
                else                 chk("b_in", b_in, sbq.pop_front());
                m_cnt--;
            end else begin
                chk("b_in_idle_zero", b_in, 0);
            end
        end
    end

    task automatic push_one(input logic [15:0] d);
        chk("count_model", dut.w_count, m_cnt);
        chk("s_ready", s_ready, (m_cnt < DEPTH));
        s_valid = 1'b1;
        s_data  = d;
        if (m_cnt < DEPTH) begin
            sbq.push_back(d);
            m_cnt++;
        end
        tick();
    endtask

    task automatic do_reset();
        mon_en    = 1'b0;
        reset     = 1'b1;
        s_valid   = 1'b0;
        out_valid = 1'b0;
        tick();
        tick();
        reset  = 1'b0;
        sbq.delete();
        m_cnt  = 0;
        mon_en = 1'b1;
    endtask

    task automatic wait_rise(input int limit, output int n);
        n = 0;
        while (in_en !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
        chk("burst_start", in_en, 1);
    endtask

    task automatic burst_len(output int len);
        len = 0;
        while (in_en === 1'b1 && len < 40) begin
            chk("burst_busy", busy, 1);
            tick();
            len++;
        end
        chk("burst_len", len, VEC_LEN);
    endtask

    // Solver model: result phase starts 18 cycles after the last in_en, lasts 16 cycles.
    task automatic solver(output int gap);
        int len;
        wait_rise(300, gap);
        burst_len(len);
        repeat (17) begin
            chk("wait_no_in_en", in_en, 0);
            chk("wait_busy", busy, 1);
            tick();
        end
        out_valid = 1'b1;
        repeat (16) begin
            tick();
            chk("resp_busy", busy, 1);
            chk("resp_no_in_en", in_en, 0);
        end
        out_valid = 1'b0;
        chk("busy_before_fall", busy, 1);
        tick();
        chk("busy_after_fall", busy, 0);
        chk("idle_in_en", in_en, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int gap, gap2, len, k;

        for (int i = 0; i < 16; i++) begin
            tbl[i] = '{din: 16'(i + 1), exp_cnt: i + 1, exp_ready: 1'b1};
        end

        // Reset state
        do_reset();
        chk("rst_in_en", in_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_s_ready", s_ready, 1);
        chk("rst_err", err, 0);
        chk("rst_b_in", b_in, 0);
        chk("rst_count", dut.w_count, 0);

        // Basic run from the table
        for (int i = 0; i < 16; i++) begin
            chk("tbl_ready", s_ready, tbl[i].exp_ready);
            push_one(tbl[i].din);
            chk("tbl_count", dut.w_count, tbl[i].exp_cnt);
        end
        s_valid = 1'b0;
        chk("thr_not_yet", in_en, 0);
        solver(gap);
        chk("basic_latency", gap, 1);
        chk("basic_count_end", dut.w_count, 0);
        chk("basic_err", err, 0);

        // Back-to-back runs
        do_reset();
        fork
            begin
                for (int i = 0; i < 32; i++) begin
                    push_one(seq);
                    seq++;
                end
                s_valid = 1'b0;
            end
            begin
                solver(gap);
                solver(gap2);
                chk("b2b_gap", gap2, 1);
            end
        join
        chk("b2b_count_end", dut.w_count, 0);

        // Threshold: 15 samples never start a burst
        do_reset();
        for (int i = 0; i < 15; i++) begin
            push_one(seq);
            seq++;
        end
        s_valid = 1'b0;
        repeat (100) begin
            chk("thr_no_in_en", in_en, 0);
            tick();
        end
        chk("thr_count15", dut.w_count, 15);
        push_one(seq);
        seq++;
        s_valid = 1'b0;
        solver(gap);
        chk("thr_latency", gap, 1);
        chk("thr_count_end", dut.w_count, 0);

        // Full FIFO, timeout, sticky err, then reset mid-burst
        do_reset();
        stop_push = 1'b0;
        fork
            begin
                k = 0;
                while (!stop_push && k < 400) begin
                    push_one(seq);
                    seq++;
                    k++;
                end
                s_valid = 1'b0;
            end
            begin
                wait_rise(300, gap);
                burst_len(len);
                repeat (TOUT) begin
                    chk("to_err_low", err, 0);
                    chk("to_busy", busy, 1);
                    tick();
                end
                chk("to_err_set", err, 1);
                chk("to_idle", busy, 0);
                chk("full_count", dut.w_count, DEPTH);
                chk("full_s_ready", s_ready, 0);
                wait_rise(5, gap2);
                chk("to_next_gap", gap2, 1);
                repeat (6) begin
                    chk("sticky_err", err, 1);
                    chk("burst2_in_en", in_en, 1);
                    tick();
                end
                stop_push = 1'b1;
                chk("burst2_in_en7", in_en, 1);
                tick();
                chk("burst2_in_en8", in_en, 1);
                reset = 1'b1;
                tick();
                chk("mid_rst_in_en", in_en, 0);
                chk("mid_rst_busy", busy, 0);
                chk("mid_rst_count", dut.w_count, 0);
                chk("mid_rst_s_ready", s_ready, 1);
                chk("mid_rst_err", err, 0);
            end
        join
        reset = 1'b0;
        sbq.delete();
        m_cnt = 0;
        tick();
        chk("post_rst_idle", busy, 0);
        chk("post_rst_b_in", b_in, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gsim_feeder.md
GSIM_FEEDER -- requirements
Module: gsim_feeder

Interface
REQ-001 Parameters (name, default, meaning):
- DEPTH, 32: FIFO entries; power of two, at least 16.
- VEC_LEN, 16: b values per solver run.
- TIMEOUT, 1024: maximum cycles spent in WAIT_RES.
REQ-002 Ports (name, direction, width, meaning):
- clk, input, 1: single clock; all flops on rising edge.
- reset, input, 1: synchronous, active-high.
- s_valid, input, 1: host b sample valid.
- s_data, input, 16: host b sample, two's-complement.
- s_ready, output, 1: feeder can accept a sample.
- in_en, output, 1: b_in valid to the GSIM solver.
- b_in, output, 16: b value to the solver.
- out_valid, input, 1: solver result-phase indicator, monitored only.
- busy, output, 1: a solver run is in progress.
- err, output, 1: sticky timeout flag.

Function
REQ-003 The sample FIFO SHALL push on s_valid && s_ready, with s_ready = (count < DEPTH).
- When s_valid is high and s_ready is low, the sample SHALL be dropped and nothing SHALL change.
REQ-004 A push and a pop in the same cycle SHALL leave count unchanged.
- Read and write pointers SHALL wrap modulo DEPTH.
- count SHALL be clog2(DEPTH)+1 bits wide.
REQ-005 The FSM SHALL have four states: IDLE, BURST, WAIT_RES, WAIT_DONE.
REQ-006 IDLE: when count >= VEC_LEN at a rising edge, the next state SHALL be BURST; otherwise the FSM SHALL stay in IDLE.
REQ-007 BURST:
- in_en SHALL be 1 for exactly VEC_LEN consecutive cycles.
- b_in SHALL equal the FIFO head, and one entry SHALL be popped per cycle.
- A 4-bit beat counter SHALL run 0..15; at beat 15 the next state SHALL be WAIT_RES.
REQ-008 WAIT_RES:
- out_valid = 1 SHALL move the FSM to WAIT_DONE.
- A wait counter reaching TIMEOUT-1 without out_valid SHALL set err and move the FSM to IDLE.
REQ-009 WAIT_DONE: out_valid = 0 SHALL move the FSM to IDLE.
REQ-010 busy SHALL be 1 in every state except IDLE.
REQ-011 in_en SHALL be 1 only in BURST.
- b_in SHALL be 0 whenever in_en = 0.
- Outputs SHALL decode registered state and FIFO storage only; there SHALL be no combinational path from s_valid or out_valid to outputs.
REQ-012 Latency:
- A sample pushed at edge N SHALL count toward the threshold at edge N+1.
- If IDLE sees count >= 16 at edge k, in_en SHALL be high in cycles k+1 .. k+16.
REQ-013 Pushes SHALL continue to be accepted in every state, including BURST.
- A burst SHALL start only when 16 samples are already buffered; there SHALL be no partial bursts.
REQ-014 Once set, err SHALL remain 1 until reset.
- err SHALL NOT block later bursts.

Reset
REQ-015 On reset:
- state SHALL be IDLE.
- pointers, count, beat counter, wait counter and err SHALL be 0.
- in_en = 0, b_in = 0, busy = 0 and s_ready = 1 SHALL hold from the next cycle.
REQ-016 Reset asserted mid-BURST or mid-wait SHALL abort the run and discard all buffered samples.
- Resetting the solver in the same cycle is the system's responsibility.

Structure
REQ-017 Package gsim_pkg SHALL hold:
- VEC_LEN = 16, B_WIDTH = 16, X_WIDTH = 32;
- the feeder state enumeration.
REQ-018 The FIFO SHALL be a separate sub-module, gsim_fifo, parameterised by width and depth.
- It SHALL provide push, pop, full, empty and count.
REQ-019 The FSM and counters SHALL reside in gsim_feeder.

Verification
REQ-020 Basic run:
- Stimulus: push 0x0001..0x0010 back-to-back; solver model raises out_valid 18 cycles after the last in_en and holds it 16 cycles.
- Response: in_en is high 16 consecutive cycles starting 1 cycle after the threshold edge; b_in = 0x0001..0x0010 in order; busy falls 1 cycle after out_valid falls.
REQ-021 Back-to-back runs:
- Stimulus: push 32 samples.
- Response: the second burst starts only after WAIT_DONE exits; b_in resumes at sample 17; no in_en between the bursts.
REQ-022 Threshold:
- Stimulus: push 15 samples, wait 100 cycles.
- Response: in_en stays 0; the 16th push triggers a burst with count dropping to 0 afterwards.
REQ-023 Full FIFO:
- Stimulus: hold s_valid = 1 continuously with no out_valid response.
- Response: s_ready = 0 exactly when count = 32; the dropped sample does not alter FIFO contents or count.
REQ-024 Timeout:
- Stimulus: run a burst; out_valid never rises.
- Response: err = 1 and state IDLE at cycle TIMEOUT after WAIT_RES entry; a subsequent burst with 16 samples proceeds normally with err still 1.
REQ-025 Reset mid-burst:
- Stimulus: assert reset on the 8th in_en cycle.
- Response: next cycle shows in_en = 0, busy = 0, count = 0, s_ready = 1, err = 0.
